regfile_write_arbiter: RTL and testbench

Sequencer and arbiter for the single write port of the 32x64 register file. After every reset it clears registers X0–X30 to zero, one per cycle. It then shares the write port between four requesters using round-robin arbitration with a valid/ready handshake. Its registered outputs drive the register file's write-enable, the 5-bit write address that feeds the address decoder tree, and the 64-bit write data.

---
 rtl/regfile_write_arbiter.sv | 151 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Sequencer and arbiter for the single write port of the 32x64 register
//   file. After every reset it clears X0..X30 (one register per cycle), then
//   shares the write port between NREQ requesters using round-robin
//   arbitration with a valid/ready handshake. All wr_* outputs are registered.
//
// Ports
//   clk        in   single clock, rising edge
//   reset_n    in   synchronous active-low reset
//   req_valid  in   [NREQ]          per-requester write request
//   req_addr   in   [NREQ*ADDR_W]   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   in   [NREQ*DATA_W]   packed data, requester i at [i*DATA_W +: DATA_W]
//   req_ready  out  [NREQ]          combinational grant, one-hot or zero
//   wr_en      out                  register-file write enable
//   wr_addr    out  [ADDR_W]        register-file write address
//   wr_data    out  [DATA_W]        register-file write data
//   grant_id   out  [2]             requester whose write is on wr_*
//   init_done  out                  high once the clear sequence has completed
module regfile_write_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [1:0]               grant_id,
    output logic                     init_done
);

    typedef enum logic {
        INIT,
        ARB
    } state_t;

    // Last register cleared; X31 (XZR) is never written.
    localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(30);
    localparam logic [ADDR_W-1:0] XZR      = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [1:0]          ptr_q, ptr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [1:0]          grant_id_q, grant_id_d;
    logic                init_done_q, init_done_d;

    logic                gnt_found;
    logic [1:0]          gnt_idx;
    logic [1:0]          scan_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    // Round-robin scan starting at ptr_q; depends only on state, ptr and
    // req_valid so there is no combinational path from the wr_* registers.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        req_ready = '0;
        if (state_q == ARB) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                scan_idx = ptr_q + 2'(i);
                if (!gnt_found && req_valid[scan_idx]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = scan_idx;
                end
            end
            if (gnt_found) begin
                req_ready[gnt_idx] = 1'b1;
            end
        end
    end

    assign sel_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_data = req_data[gnt_idx*DATA_W +: DATA_W];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        grant_id_d  = grant_id_q;
        init_done_d = init_done_q;
        case (state_q)
            INIT: begin
                wr_en_d    = 1'b1;
                wr_addr_d  = cnt_q;
                wr_data_d  = '0;
                grant_id_d = '0;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_CLR) begin
                    state_d     = ARB;
                    init_done_d = 1'b1;
                end
            end
            ARB: begin
                if (gnt_found) begin
                    // A write to XZR is accepted (ptr advances, wr_* update)
                    // but never enabled towards the register file.
                    wr_en_d    = (sel_addr != XZR);
                    wr_addr_d  = sel_addr;
                    wr_data_d  = sel_data;
                    grant_id_d = gnt_idx;
                    ptr_d      = gnt_idx + 2'd1;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            ptr_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            grant_id_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            grant_id_q  <= grant_id_d;
            init_done_q <= init_done_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign grant_id  = grant_id_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic         clk;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [19:0]  req_addr;
    logic [255:0] req_data;
    logic [3:0]   req_ready;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [63:0]  wr_data;
    logic [1:0]   grant_id;
    logic         init_done;

    regfile_write_arbiter #(.NREQ(4), .ADDR_W(5), .DATA_W(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .init_done (init_done)
    );

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [63:0] data;
        logic [1:0]  gid;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Requester-side view: a request stays pending (stable) until granted.
    bit          pend[4];
    logic [4:0]  p_addr[4];
    logic [63:0] p_data[4];

    // Reference model: clear progress, round-robin pointer, held outputs.
    bit          m_init;
    bit          m_done;
    int          m_clr;
    int          m_ptr;
    logic [4:0]  m_addr;
    logic [63:0] m_data;
    logic [1:0]  m_gid;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: every edge the DUT presents a new registered output word.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (wr_en !== e.en) begin
                    errors++;
                    $display("FAIL wr_en t=%0t got %b required %b", $time, wr_en, e.en);
                end
                checks++;
                if (wr_addr !== e.addr) begin
                    errors++;
                    $display("FAIL wr_addr t=%0t got %0d required %0d", $time, wr_addr, e.addr);
                end
                checks++;
                if (wr_data !== e.data) begin
                    errors++;
                    $display("FAIL wr_data t=%0t got %h required %h", $time, wr_data, e.data);
                end
                checks++;
                if (grant_id !== e.gid) begin
                    errors++;
                    $display("FAIL grant_id t=%0t got %0d required %0d", $time, grant_id, e.gid);
                end
                checks++;
                if (init_done !== e.done) begin
                    errors++;
                    $display("FAIL init_done t=%0t got %b required %b", $time, init_done, e.done);
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [4:0] a, input logic [63:0] d);
        pend[i]   = 1'b1;
        p_addr[i] = a;
        p_data[i] = d;
    endtask

    // One clock cycle: drive at posedge+2, check req_ready and predict the
    // next registered output at negedge, then advance to the next posedge+2.
    task automatic run_cycle(input bit rst);
        int         g;
        int         j;
        logic [3:0] exp_rdy;
        exp_t       e;
        reset_n = rst ? 1'b0 : 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid[i]        = pend[i];
            req_addr[i*5 +: 5]  = p_addr[i];
            req_data[i*64 +: 64] = p_data[i];
        end
        #3;
        g = -1;
        if (!m_init) begin
            for (int k = 0; k < 4; k++) begin
                j = (m_ptr + k) % 4;
                if (g < 0 && pend[j]) g = j;
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL req_ready t=%0t got %b required %b", $time, req_ready, exp_rdy);
        end
        if (g >= 0) pend[g] = 1'b0;
        if (rst) begin
            m_init = 1'b1; m_done = 1'b0; m_clr = 0; m_ptr = 0;
            m_addr = '0; m_data = '0; m_gid = '0;
            e = '{en: 1'b0, addr: 5'd0, data: 64'd0, gid: 2'd0, done: 1'b0};
        end else if (m_init) begin
            if (m_clr == 30) begin
                m_init = 1'b0;
                m_done = 1'b1;
            end
            m_addr = 5'(m_clr); m_data = '0; m_gid = '0;
            e = '{en: 1'b1, addr: m_addr, data: 64'd0, gid: 2'd0, done: m_done};
            m_clr++;
        end else if (g >= 0) begin
            m_addr = p_addr[g]; m_data = p_data[g]; m_gid = 2'(g);
            m_ptr  = (g + 1) % 4;
            e = '{en: (m_addr != 5'd31), addr: m_addr, data: m_data, gid: m_gid, done: 1'b1};
        end else begin
            e = '{en: 1'b0, addr: m_addr, data: m_data, gid: m_gid, done: m_done};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic random_refill();
        for (int i = 0; i < 4; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1)
                set_req(i, 5'($urandom_range(0, 31)), {$urandom, $urandom});
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0;
        end
        m_init = 1'b1; m_done = 1'b0; m_clr = 0; m_ptr = 0;
        m_addr = '0; m_data = '0; m_gid = '0;
        @(posedge clk);
        #2;

        // Reset, then clear sequence with every requester valid throughout.
        run_cycle(1'b1);
        for (int i = 0; i < 4; i++) set_req(i, 5'($urandom_range(0, 30)), {$urandom, $urandom});
        for (int c = 0; c < 31; c++) run_cycle(1'b0);
        for (int c = 0; c < 6; c++) run_cycle(1'b0);

        // Single requester 2.
        set_req(2, 5'd7, 64'hDEADBEEF_00000001);
        run_cycle(1'b0);
        run_cycle(1'b0);
        run_cycle(1'b0);

        // Bring pointer back to 0, then all four continuously valid.
        set_req(3, 5'd12, {$urandom, $urandom});
        run_cycle(1'b0);
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 4; i++)
                if (!pend[i]) set_req(i, 5'($urandom_range(0, 30)), {$urandom, $urandom});
            run_cycle(1'b0);
        end
        for (int c = 0; c < 4; c++) run_cycle(1'b0);

        // XZR write from requester 1, requester 2 also waiting.
        set_req(1, 5'd31, 64'h0123_4567_89AB_CDEF);
        set_req(2, 5'd9, {$urandom, $urandom});
        for (int c = 0; c < 3; c++) run_cycle(1'b0);

        // Requesters 0 and 3 with pointer at 3.
        set_req(0, 5'd4, {$urandom, $urandom});
        set_req(3, 5'd5, {$urandom, $urandom});
        for (int c = 0; c < 3; c++) run_cycle(1'b0);

        // Random traffic with a reset in the middle of it.
        for (int c = 0; c < 150; c++) begin
            random_refill();
            run_cycle(c == 60);
        end
        for (int c = 0; c < 6; c++) run_cycle(1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
